// File: rtl/decode_stage.sv
// decode_stage: pipelined field decode with valid/ready and 1-entry skid.
// Option: DECODE_ILLEGAL_CHECK_EN adds a registered illegal-opcode flag.
module decode_stage #(
    parameter int INSTR_W = 32,
    parameter int OPC_W   = 7,
    parameter int REG_W   = 5,
    parameter int DATA_W  = 32,
    parameter int NUM_OPS = 64,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OPC_W-1:0]   operation,
    output logic [REG_W-1:0]   r1,
    output logic [REG_W-1:0]   r2,
    output logic [REG_W-1:0]   r3,
    output logic [DATA_W-1:0]  L,
    output logic [DATA_W-1:0]  shamt,
    output logic [DATA_W-1:0]  imm_addr,
    output logic               illegal,
    output logic [CNT_W-1:0]   instr_cnt
);
    localparam int LW = INSTR_W - OPC_W;
    localparam int SW = LW - REG_W;
    localparam int IW = LW - 2 * REG_W;

    typedef struct packed {
        logic [OPC_W-1:0]  op;
        logic [REG_W-1:0]  r1;
        logic [REG_W-1:0]  r2;
        logic [REG_W-1:0]  r3;
        logic [DATA_W-1:0] l;
        logic [DATA_W-1:0] sh;
        logic [DATA_W-1:0] im;
    } fields_t;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t  state;
    fields_t dec;
    fields_t out_q;
    fields_t skid_q;

    logic signed [LW-1:0] l_raw;
    logic        [SW-1:0] sh_raw;
    logic signed [IW-1:0] im_raw;

    logic accept;
    logic emit;
    logic ld_new;
    logic ld_mv;
    logic ld_skid;

    assign accept = in_valid & in_ready;
    assign emit   = out_valid & out_ready;

    // Output register takes the new word when nothing older is waiting
    assign ld_new  = !flush && accept &&
                     (state == EMPTY || (state == ONE && emit));
    assign ld_mv   = !flush && state == TWO && emit;
    assign ld_skid = !flush && accept && state == ONE && !emit;

    // Split the incoming word into fields and extend immediates
    always_comb begin
        l_raw  = instr_in[LW-1:0];
        sh_raw = instr_in[SW-1:0];
        im_raw = instr_in[IW-1:0];
        dec    = '0;
        dec.op = instr_in[INSTR_W-1 -: OPC_W];
        dec.r1 = instr_in[LW-1 -: REG_W];
        dec.r2 = instr_in[LW-REG_W-1 -: REG_W];
        dec.r3 = instr_in[LW-2*REG_W-1 -: REG_W];
        dec.l  = DATA_W'(l_raw);
        dec.sh = DATA_W'(sh_raw);
        dec.im = DATA_W'(im_raw);
    end

    // Occupancy FSM with registered handshake outputs and emit counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            instr_cnt <= '0;
        end else begin
            if (emit)
                instr_cnt <= instr_cnt + CNT_W'(1);
            if (flush) begin
                state     <= EMPTY;
                out_valid <= 1'b0;
                in_ready  <= 1'b1;
            end else begin
                unique case (state)
                    EMPTY: if (accept) begin
                        state     <= ONE;
                        out_valid <= 1'b1;
                    end
                    ONE: if (accept && !emit) begin
                        state    <= TWO;
                        in_ready <= 1'b0;
                    end else if (emit && !accept) begin
                        state     <= EMPTY;
                        out_valid <= 1'b0;
                    end
                    TWO: if (emit) begin
                        state    <= ONE;
                        in_ready <= 1'b1;
                    end
                    default: begin
                        state     <= EMPTY;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                endcase
            end
        end
    end

    // Field datapath: output register and skid buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            if (ld_new)
                out_q <= dec;
            else if (ld_mv)
                out_q <= skid_q;
            if (ld_skid)
                skid_q <= dec;
        end
    end

    assign operation = out_q.op;
    assign r1        = out_q.r1;
    assign r2        = out_q.r2;
    assign r3        = out_q.r3;
    assign L         = out_q.l;
    assign shamt     = out_q.sh;
    assign imm_addr  = out_q.im;

`ifdef DECODE_ILLEGAL_CHECK_EN
    logic ill_in;
    logic ill_q;
    logic ill_skid;

    assign ill_in = 32'(dec.op) >= 32'(NUM_OPS);

    // Illegal flag follows its instruction through both registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ill_q    <= 1'b0;
            ill_skid <= 1'b0;
        end else begin
            if (ld_new)
                ill_q <= ill_in;
            else if (ld_mv)
                ill_q <= ill_skid;
            if (ld_skid)
                ill_skid <= ill_in;
        end
    end

    assign illegal = ill_q & out_valid;
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Parametrised, pipelined instruction decode stage between the fetch unit and the register file/ALU/PC incrementor.
- Splits each instruction word into the following fields:
  - opcode
  - three register specifiers
  - jump offset L
  - shift/long immediate
  - short immediate
- Extends L and the immediates to DATA_W and registers everything behind a valid/ready handshake with a 1-entry skid buffer.
- Provides flush, an illegal-opcode flag and a decoded-instruction counter.

Parameters:
INSTR_W, 32, instruction word width
OPC_W, 7, opcode width, taken from the MSBs
REG_W, 5, register specifier width
DATA_W, 32, width of extended L/shamt/imm outputs; must be >= INSTR_W-OPC_W
NUM_OPS, 64, opcodes 0..NUM_OPS-1 are legal
CNT_W, 16, decoded-instruction counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  instr_in is valid
in_ready  out  1  stage can accept; registered
instr_in  in  INSTR_W  instruction word
flush  in  1  discard all held instructions
out_valid  out  1  decoded fields valid
out_ready  in  1  consumer accepts
operation  out  OPC_W  instr[INSTR_W-1 -: OPC_W]
r1  out  REG_W  next REG_W bits below opcode
r2  out  REG_W  next REG_W bits
r3  out  REG_W  next REG_W bits
L  out  DATA_W  instr[INSTR_W-OPC_W-1:0], sign-extended
shamt  out  DATA_W  instr[INSTR_W-OPC_W-REG_W-1:0], zero-extended
imm_addr  out  DATA_W  instr[INSTR_W-OPC_W-2*REG_W-1:0], sign-extended
illegal  out  1  operation >= NUM_OPS
instr_cnt  out  CNT_W  count of output handshakes

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0, in_ready=1, instr_cnt=0.
  - All field outputs and illegal reset to 0; skid buffer empty.
- Handshakes: accept = in_valid & in_ready; emit = out_valid & out_ready.
- Latency: an accepted instruction appears on the outputs the next cycle, provided no older instruction is held.
- Decode is combinational on the incoming word; only registered values drive the outputs.
- State machine over held entries:
  - EMPTY: out_valid=0, in_ready=1.
    - accept -> ONE (output register loaded).
  - ONE: out_valid=1, in_ready=1.
    - accept & emit -> ONE (output reloaded with the new word).
    - emit only -> EMPTY.
    - accept only -> TWO (new word goes to the skid buffer, output held).
    - neither -> ONE, outputs stable.
  - TWO: out_valid=1, in_ready=0.
    - emit -> ONE (skid contents move to the output register).
    - otherwise -> TWO, outputs stable.
- Outputs must not change while out_valid=1 and out_ready=0.
- Order is strictly FIFO; no instruction may be dropped or duplicated, except by flush.
- Flush (synchronous, highest priority):
  - Next state EMPTY, out_valid=0, in_ready=1 on the next cycle.
  - A same-cycle accept is discarded.
  - A same-cycle emit still counts in instr_cnt.
  - Field outputs keep their last values.
- instr_cnt:
  - Increments by 1 on each emit.
  - Wraps from 2^CNT_W-1 to 0.
  - Unaffected by flush.
- Extension:
  - L and imm_addr are sign-extended from their MSB to DATA_W.
  - shamt is zero-extended to DATA_W.
- Reset asserted mid-stream: all held instructions are lost, with no partial outputs.
- Back-to-back traffic with out_ready=1 sustains 1 instruction/cycle.

Optional Feature:
- Macro: DECODE_ILLEGAL_CHECK_EN.
- When defined:
  - illegal is registered alongside the fields: 1 when operation >= NUM_OPS.
  - It is qualified by out_valid and travels through the skid buffer with its instruction.
- When undefined:
  - illegal is tied to 0 and no comparator is built.
  - All other behaviour is identical.

Test Plan:
1. Reset, then a single instruction:
   - Stimulus: rst_n low, then release; instr_in=0x12345678, in_valid=1 for one cycle, out_ready=1.
   - Required response, next cycle: out_valid=1, operation=0x09, r1=0x03, r2=0x08, r3=0x15, L=0x00345678, shamt=0x00045678, imm_addr=0xFFFFD678; then instr_cnt=1.
2. Stall and skid:
   - Stimulus: out_ready=0, three words A, B, C offered on consecutive cycles.
   - Required response: A is held on the outputs, B is taken into the skid buffer, in_ready=0 while C is stalled.
   - Then with out_ready=1: A, B, C emerge in order on consecutive cycles; instr_cnt advances by 3.
3. Streaming:
   - Stimulus: 100 consecutive words with in_valid=1 and out_ready=1.
   - Required response: 100 emits in 101 cycles, in_ready never 0, instr_cnt=100.
4. Flush in TWO with a simultaneous offer:
   - Stimulus: flush=1 in TWO while in_valid=1.
   - Required response, next cycle: out_valid=0, in_ready=1; the offered word never appears; the next accepted word appears with latency 1.
5. Counter wrap and illegal flag:
   - Counter: CNT_W=4, 17 emits -> instr_cnt=1.
   - Illegal flag with DECODE_ILLEGAL_CHECK_EN: opcode 0x40 -> illegal=1; opcode 0x3F -> illegal=0. Without the macro, illegal stays 0.
6. Asynchronous reset in TWO:
   - Stimulus: rst_n asserted mid-cycle while in TWO.
   - Required response: out_valid=0 and instr_cnt=0 immediately, with no clock edge needed; first accept after release decodes correctly.
